pps_capture: RTL

- Receive side of the PPS path: synchronises an external pps_in and rejects glitches.
- Stamps each qualified rising edge with the free-running timestamp from pps_timer.
- Measures edge-to-edge period and tracks lock against a nominal 1 s period.
- Sits beside pps_timer in the clk_pps domain (120 MHz); outputs feed the accumulator-increment calibration logic.

---
 rtl/pps_pkg.sv | 13 +
 rtl/pps_edge_qualifier.sv | 63 ++++++
 rtl/pps_capture.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pps_pkg.sv
// Shared PPS-path types and timestamp constants, used by pps_capture and pps_timer.
package pps_pkg;

    localparam int unsigned PPS_TS_WIDTH       = 64;
    localparam logic [63:0] PPS_PERIOD_NOMINAL = 64'd1_000_000_000;

    typedef logic [1:0] pps_state_t;

    localparam pps_state_t ST_UNLOCKED = 2'd0;
    localparam pps_state_t ST_ACQUIRE  = 2'd1;
    localparam pps_state_t ST_LOCKED   = 2'd2;

endpackage : pps_pkg

// File: rtl/pps_edge_qualifier.sv
// Synchronises pps_in, latches the timestamp on each synchronised rising edge and
// qualifies the edge once the input has stayed high for MIN_HIGH_CYCLES cycles.
module pps_edge_qualifier import pps_pkg::*; #(
    parameter int unsigned TS_WIDTH        = PPS_TS_WIDTH,
    parameter int unsigned MIN_HIGH_CYCLES = 8
) (
    input  logic                clk_pps,
    input  logic                reset_pps,
    input  logic                i_pps,
    input  logic [TS_WIDTH-1:0] i_timestamp,
    output logic                o_qual_c,
    output logic                o_glitch_c,
    output logic [TS_WIDTH-1:0] o_ts_hold
);

    localparam int unsigned CNT_W = $clog2(MIN_HIGH_CYCLES + 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_s_d;
    logic                r_pend;
    logic [CNT_W-1:0]    r_cnt;
    logic [TS_WIDTH-1:0] r_ts_hold;

    logic w_rise;
    logic w_qual;
    logic w_glitch;

    assign w_rise   = r_sync2 && !r_s_d;
    // A single-cycle filter qualifies on the edge itself; otherwise on the last required high cycle.
    assign w_qual   = (w_rise && (MIN_HIGH_CYCLES == 1)) ||
                      (r_pend && r_sync2 && (r_cnt == CNT_W'(MIN_HIGH_CYCLES - 1)));
    assign w_glitch = r_pend && !r_sync2;

    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_s_d     <= 1'b0;
            r_pend    <= 1'b0;
            r_cnt     <= '0;
            r_ts_hold <= '0;
        end else begin
            r_sync1 <= i_pps;
            r_sync2 <= r_sync1;
            r_s_d   <= r_sync2;
            if (w_rise) begin
                r_ts_hold <= i_timestamp;
                r_cnt     <= CNT_W'(1);
                r_pend    <= (MIN_HIGH_CYCLES > 1);
            end else if (w_qual || w_glitch) begin
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_qual_c   = w_qual;
    assign o_glitch_c = w_glitch;
    assign o_ts_hold  = r_ts_hold;

endmodule : pps_edge_qualifier

// File: rtl/pps_capture.sv
// PPS receive path: timestamps qualified edges, measures the edge-to-edge period
// and tracks lock against the nominal period, with timeout and glitch counters.
module pps_capture import pps_pkg::*; #(
    parameter int unsigned          TS_WIDTH        = PPS_TS_WIDTH,
    parameter logic [TS_WIDTH-1:0]  PERIOD_NOMINAL  = TS_WIDTH'(PPS_PERIOD_NOMINAL),
    parameter logic [TS_WIDTH-1:0]  PERIOD_TOL      = TS_WIDTH'(1_000),
    parameter int unsigned          MIN_HIGH_CYCLES = 8,
    parameter int unsigned          TIMEOUT_CYCLES  = 180_000_000,
    parameter int unsigned          MISS_WIDTH      = 16
) (
    input  logic                  clk_pps,
    input  logic                  reset_pps,
    input  logic                  pps_in,
    input  logic [TS_WIDTH-1:0]   timestamp,
    output logic                  cap_valid,
    output logic [TS_WIDTH-1:0]   cap_ts,
    output logic [TS_WIDTH-1:0]   cap_period,
    output logic                  period_ok,
    output logic                  locked,
    output logic [MISS_WIDTH-1:0] missed_count,
    output logic [MISS_WIDTH-1:0] glitch_count
);

    localparam int unsigned         TO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TS_WIDTH-1:0] PER_LO = PERIOD_NOMINAL - PERIOD_TOL;
    localparam logic [TS_WIDTH-1:0] PER_HI = PERIOD_NOMINAL + PERIOD_TOL;

    logic                  w_qual;
    logic                  w_glitch;
    logic [TS_WIDTH-1:0]   w_ts_hold;
    logic [TS_WIDTH-1:0]   w_period;
    logic                  w_in_win;
    logic                  w_timeout;
    pps_state_t            w_state_nxt;

    pps_state_t            r_state;
    logic                  r_cap_valid;
    logic [TS_WIDTH-1:0]   r_cap_ts;
    logic [TS_WIDTH-1:0]   r_cap_period;
    logic                  r_period_ok;
    logic                  r_locked;
    logic [TS_WIDTH-1:0]   r_prev_ts;
    logic [TO_W-1:0]       r_to_cnt;
    logic [MISS_WIDTH-1:0] r_missed;
    logic [MISS_WIDTH-1:0] r_glitch;

    pps_edge_qualifier #(
        .TS_WIDTH        (TS_WIDTH),
        .MIN_HIGH_CYCLES (MIN_HIGH_CYCLES)
    ) u_qual (
        .clk_pps     (clk_pps),
        .reset_pps   (reset_pps),
        .i_pps       (pps_in),
        .i_timestamp (timestamp),
        .o_qual_c    (w_qual),
        .o_glitch_c  (w_glitch),
        .o_ts_hold   (w_ts_hold)
    );

    // Modular subtraction absorbs timestamp wrap.
    assign w_period  = w_ts_hold - r_prev_ts;
    assign w_in_win  = (w_period >= PER_LO) && (w_period <= PER_HI);
    assign w_timeout = (r_state != ST_UNLOCKED) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state: a qualified edge takes priority over a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        if (w_qual) begin
            case (r_state)
                ST_UNLOCKED: w_state_nxt = ST_ACQUIRE;
                ST_ACQUIRE,
                ST_LOCKED:   w_state_nxt = w_in_win ? ST_LOCKED : ST_ACQUIRE;
                default:     w_state_nxt = ST_UNLOCKED;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_UNLOCKED;
        end
    end

    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            r_state      <= ST_UNLOCKED;
            r_cap_valid  <= 1'b0;
            r_cap_ts     <= '0;
            r_cap_period <= '0;
            r_period_ok  <= 1'b0;
            r_locked     <= 1'b0;
            r_prev_ts    <= '0;
            r_to_cnt     <= '0;
            r_missed     <= '0;
            r_glitch     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_locked    <= (r_state == ST_LOCKED);
            r_cap_valid <= w_qual;

            if (w_qual) begin
                r_cap_ts     <= w_ts_hold;
                r_cap_period <= (r_state == ST_UNLOCKED) ? '0 : w_period;
                r_period_ok  <= (r_state != ST_UNLOCKED) && w_in_win;
                r_prev_ts    <= w_ts_hold;
            end else if (w_timeout) begin
                r_period_ok <= 1'b0;
            end

            if (w_qual || w_timeout) begin
                r_to_cnt <= '0;
            end else if (r_state != ST_UNLOCKED) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_timeout && !w_qual && (r_missed != '1)) begin
                r_missed <= r_missed + MISS_WIDTH'(1);
            end
            if (w_glitch && (r_glitch != '1)) begin
                r_glitch <= r_glitch + MISS_WIDTH'(1);
            end
        end
    end

    assign cap_valid    = r_cap_valid;
    assign cap_ts       = r_cap_ts;
    assign cap_period   = r_cap_period;
    assign period_ok    = r_period_ok;
    assign locked       = r_locked;
    assign missed_count = r_missed;
    assign glitch_count = r_glitch;

endmodule : pps_capture
